// File: rtl/multi_stage_caesar_pipeline.sv
// multi_stage_caesar_pipeline: N-stage pipelined Caesar cipher with per-stage key table; PASSTHRU_NONALPHA_EN passes non-letters through unchanged
module multi_stage_caesar_pipeline #(
  parameter int NUM_STAGES = 3,
  parameter int IDX_W      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_char,
  input  logic             in_decrypt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_char,
  output logic             out_err_char,
  input  logic             key_wr_en,
  input  logic [IDX_W-1:0] key_wr_idx,
  input  logic [4:0]       key_wr_shift,
  input  logic             key_wr_dir,
  output logic             busy,
  output logic             err_key_wr
);
  typedef struct packed {
    logic       v;
    logic       dec;
    logic       up;
    logic       alpha;
    logic [7:0] ch;
  } stage_t;
  stage_t     st_q [NUM_STAGES];
  stage_t     st_d [NUM_STAGES];
  stage_t     src  [NUM_STAGES];
  logic [4:0] ksh_q [NUM_STAGES];
  logic [4:0] ksh_d [NUM_STAGES];
  logic       kdir_q [NUM_STAGES];
  logic       kdir_d [NUM_STAGES];
  logic       err_key_wr_q, err_key_wr_d;
  logic       advance, key_ok, in_up, in_lo;
  function automatic logic [7:0] rot(input logic [7:0] ch, input logic up, input logic [4:0] k, input logic left);
    logic [7:0] base;
    logic [5:0] off, t;
    base = up ? 8'h41 : 8'h61;
    off  = 6'(ch - base);
    t    = left ? off - {1'b0, k} : off + {1'b0, k};
    t    = left ? (t[5] ? t + 6'd26 : t) : (t >= 6'd26 ? t - 6'd26 : t);
    return base + {2'b00, t};
  endfunction
  assign in_up        = in_char >= 8'h41 && in_char <= 8'h5A;
  assign in_lo        = in_char >= 8'h61 && in_char <= 8'h7A;
  assign out_valid    = st_q[NUM_STAGES-1].v;
  assign advance      = !out_valid || out_ready;
  assign in_ready     = advance;
  assign err_key_wr   = err_key_wr_q;
`ifdef PASSTHRU_NONALPHA_EN
  assign out_char     = st_q[NUM_STAGES-1].ch;
  assign out_err_char = 1'b0;
`else
  assign out_char     = st_q[NUM_STAGES-1].alpha ? st_q[NUM_STAGES-1].ch : 8'h00;
  assign out_err_char = st_q[NUM_STAGES-1].v && !st_q[NUM_STAGES-1].alpha;
`endif
  // any stage holding a character makes the pipeline busy
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) busy = busy | st_q[i].v;
  end
  // shift all stages together on advance; each stage rotates letters by its key (mirrored and inverted for decrypt)
  always_comb begin
    src[0] = '{v: in_valid, dec: in_decrypt, up: in_up, alpha: in_up || in_lo, ch: in_char};
    for (int i = 1; i < NUM_STAGES; i++) src[i] = st_q[i-1];
    for (int i = 0; i < NUM_STAGES; i++) begin
      st_d[i] = advance ? src[i] : st_q[i];
      if (advance && src[i].alpha)
        st_d[i].ch = rot(src[i].ch, src[i].up,
                         src[i].dec ? ksh_q[NUM_STAGES-1-i] : ksh_q[i],
                         src[i].dec ? !kdir_q[NUM_STAGES-1-i] : kdir_q[i]);
    end
  end
  // key writes only land when the pipeline is empty and no character is arriving
  always_comb begin
    key_ok = key_wr_en && !busy && !in_valid && (32'(key_wr_idx) < NUM_STAGES) && key_wr_shift <= 5'd25;
    err_key_wr_d = key_wr_en && !key_ok;
    for (int j = 0; j < NUM_STAGES; j++) begin
      ksh_d[j]  = key_ok && key_wr_idx == IDX_W'(j) ? key_wr_shift : ksh_q[j];
      kdir_d[j] = key_ok && key_wr_idx == IDX_W'(j) ? key_wr_dir : kdir_q[j];
    end
  end
  // state registers; reset flushes in-flight characters and restores identity keys
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        st_q[i]   <= '0;
        ksh_q[i]  <= '0;
        kdir_q[i] <= 1'b0;
      end
      err_key_wr_q <= 1'b0;
    end else begin
      st_q         <= st_d;
      ksh_q        <= ksh_d;
      kdir_q       <= kdir_d;
      err_key_wr_q <= err_key_wr_d;
    end
  end
endmodule

// File: tb/tb_multi_stage_caesar_pipeline.sv
// tb_multi_stage_caesar_pipeline: scoreboard bench for the pipelined Caesar cipher
module tb_multi_stage_caesar_pipeline;
  logic       clk = 1'b0, rst = 1'b1;
  logic       in_valid = 1'b0, in_decrypt = 1'b0, out_ready = 1'b1;
  logic [7:0] in_char = 8'h00;
  logic       key_wr_en = 1'b0, key_wr_dir = 1'b0;
  logic [2:0] key_wr_idx = 3'd0;
  logic [4:0] key_wr_shift = 5'd0;
  logic       in_ready, out_valid, out_err_char, busy, err_key_wr;
  logic [7:0] out_char;
  int         n_chk = 0, n_pass = 0, acc = 0, lat = 0;
  logic [8:0] sb [$];
  logic [8:0] mon_e;
  logic [7:0] held;
  logic [7:0] s_ch  [8];
  logic       s_dec [8];
  logic [8:0] s_exp [8];
`ifdef PASSTHRU_NONALPHA_EN
  localparam logic [8:0] NA5 = {1'b0, 8'h35};
`else
  localparam logic [8:0] NA5 = {1'b1, 8'h00};
`endif

  multi_stage_caesar_pipeline #(.NUM_STAGES(3), .IDX_W(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
    .in_decrypt(in_decrypt), .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char),
    .out_err_char(out_err_char), .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx),
    .key_wr_shift(key_wr_shift), .key_wr_dir(key_wr_dir), .busy(busy), .err_key_wr(err_key_wr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic put(input int i, input logic [7:0] ch, input logic dec, input logic [8:0] exp);
    s_ch[i] = ch;
    s_dec[i] = dec;
    s_exp[i] = exp;
  endtask

  task automatic feed(input int n);
    int i, cyc;
    i = 0;
    cyc = 0;
    acc = 0;
    while (i < n && cyc < 200) begin
      in_valid = 1'b1;
      in_char = s_ch[i];
      in_decrypt = s_dec[i];
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(s_exp[i]);
        i++;
        acc = i;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    if (i < n) chk("feed_timeout", 32'(i), 32'(n));
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (sb.size() != 0 && c < 100) begin
      @(posedge clk);
      #1;
      c++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain_empty", 32'(sb.size()), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic wkey(input logic [2:0] idx, input logic [4:0] sh, input logic dir, input logic exp_err);
    key_wr_en = 1'b1;
    key_wr_idx = idx;
    key_wr_shift = sh;
    key_wr_dir = dir;
    @(posedge clk);
    #1;
    key_wr_en = 1'b0;
    chk("key_err_pulse", 32'(err_key_wr), 32'(exp_err));
    @(posedge clk);
    #1;
    chk("key_err_clear", 32'(err_key_wr), 32'd0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_out", 32'({out_err_char, out_char}), 32'hFFFF_FFFF);
        else begin
          mon_e = sb.pop_front();
          chk("out_char", 32'(out_char), 32'(mon_e[7:0]));
          chk("out_err_char", 32'(out_err_char), 32'(mon_e[8]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_char", 32'(out_char), 32'd0);
    chk("rst_out_err", 32'(out_err_char), 32'd0);
    chk("rst_key_err", 32'(err_key_wr), 32'd0);
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    // identity keys and latency
    in_valid = 1'b1;
    in_char = 8'h41;
    in_decrypt = 1'b0;
    sb.push_back({1'b0, 8'h41});
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      in_valid = 1'b0;
    end while (!out_valid && lat < 20);
    chk("latency", 32'(lat), 32'd3);
    drain();
    // net +8 key set
    wkey(3'd0, 5'd3, 1'b0, 1'b0);
    wkey(3'd1, 5'd5, 1'b1, 1'b0);
    wkey(3'd2, 5'd10, 1'b0, 1'b0);
    put(0, 8'h41, 1'b0, {1'b0, 8'h49});
    put(1, 8'h7A, 1'b0, {1'b0, 8'h68});
    put(2, 8'h49, 1'b1, {1'b0, 8'h41});
    put(3, 8'h68, 1'b1, {1'b0, 8'h7A});
    feed(4);
    drain();
    // non-letter between letters
    put(0, 8'h42, 1'b0, {1'b0, 8'h4A});
    put(1, 8'h35, 1'b0, NA5);
    put(2, 8'h63, 1'b0, {1'b0, 8'h6B});
    feed(3);
    drain();
    // backpressure
    put(0, 8'h61, 1'b0, {1'b0, 8'h69});
    put(1, 8'h62, 1'b0, {1'b0, 8'h6A});
    put(2, 8'h63, 1'b0, {1'b0, 8'h6B});
    put(3, 8'h64, 1'b0, {1'b0, 8'h6C});
    put(4, 8'h65, 1'b0, {1'b0, 8'h6D});
    out_ready = 1'b0;
    fork
      feed(5);
      begin
        repeat (3) @(posedge clk);
        #1;
        held = out_char;
        chk("bp_head", 32'(held), 32'h69);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_accepted", 32'(acc), 32'd3);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_stable", 32'(out_char), 32'(held));
        out_ready = 1'b1;
      end
    join
    drain();
    // rejected key writes leave the table unchanged
    wkey(3'd0, 5'd26, 1'b0, 1'b1);
    wkey(3'd3, 5'd1, 1'b0, 1'b1);
    put(0, 8'h41, 1'b0, {1'b0, 8'h49});
    feed(1);
    wkey(3'd0, 5'd7, 1'b0, 1'b1);
    drain();
    feed(1);
    drain();
    // reset with a full pipeline
    out_ready = 1'b0;
    put(0, 8'h78, 1'b0, {1'b0, 8'h00});
    put(1, 8'h79, 1'b0, {1'b0, 8'h00});
    put(2, 8'h7A, 1'b0, {1'b0, 8'h00});
    feed(3);
    chk("full_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_out_char", 32'(out_char), 32'd0);
    out_ready = 1'b1;
    put(0, 8'h41, 1'b0, {1'b0, 8'h41});
    put(1, 8'h7A, 1'b1, {1'b0, 8'h7A});
    feed(2);
    drain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
